// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: WIDTH-bit word in over valid/ready, MSB-first bit stream out.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] PI,
   output logic             SO,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
`ifdef PISO_PARITY_EN
      PAR,
`endif
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             handshake;
`ifdef PISO_PARITY_EN
   logic             parity;
`endif

   // Ready in IDLE, or on the final-bit cycle so frames can stream back to back.
   assign load_ready = (state == IDLE) || so_last;
   assign handshake  = load_valid && load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sreg     <= '0;
         cnt      <= '0;
         SO       <= 1'b0;
         so_valid <= 1'b0;
         so_last  <= 1'b0;
         busy     <= 1'b0;
`ifdef PISO_PARITY_EN
         parity   <= 1'b0;
`endif
      end else if (handshake) begin
         state    <= SHIFT;
         sreg     <= PI;
         cnt      <= '0;
         SO       <= PI[WIDTH-1];
         so_valid <= 1'b1;
         so_last  <= 1'b0;
         busy     <= 1'b1;
`ifdef PISO_PARITY_EN
         parity   <= ^PI;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt == LAST_DATA) begin
`ifdef PISO_PARITY_EN
                  state   <= PAR;
                  cnt     <= cnt + CW'(1);
                  SO      <= parity;
                  so_last <= 1'b1;
`else
                  state    <= IDLE;
                  SO       <= 1'b0;
                  so_valid <= 1'b0;
                  so_last  <= 1'b0;
                  busy     <= 1'b0;
`endif
               end else begin
                  // Rotate so SO always takes the next bit below the one just sent.
                  sreg <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                  SO   <= sreg[WIDTH-2];
                  cnt  <= cnt + CW'(1);
`ifndef PISO_PARITY_EN
                  so_last <= (cnt == (LAST_DATA - CW'(1)));
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
               state    <= IDLE;
               SO       <= 1'b0;
               so_valid <= 1'b0;
               so_last  <= 1'b0;
               busy     <= 1'b0;
            end
`endif
            default: begin
               state    <= IDLE;
               SO       <= 1'b0;
               so_valid <= 1'b0;
               so_last  <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=4); honours PISO_PARITY_EN like the design.
module tb_piso_serializer;

   localparam int unsigned WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] PI;
   logic             SO;
   logic             so_valid;
   logic             so_last;
   logic             busy;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   int          n_last = 0;
   logic [3:0]  sipo_q = '0;

   piso_serializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .PI         (PI),
      .SO         (SO),
      .so_valid   (so_valid),
      .so_last    (so_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Downstream 4-bit SIPO on the same clock.
   always @(posedge clk) sipo_q <= {sipo_q[2:0], SO};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: every frame bit is popped and compared against the scoreboard.
   always @(negedge clk) begin
      if (!rst && so_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_bit", 32'(so_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("so", 32'(SO), 32'(e.b));
            check("so_last", 32'(so_last), 32'(e.l));
            check("busy", 32'(busy), 32'd1);
            if (so_last) n_last++;
         end
      end
   end

   task automatic push_word(input logic [WIDTH-1:0] w);
      exp_t e;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         e.b = w[i];
`ifdef PISO_PARITY_EN
         e.l = 1'b0;
`else
         e.l = (i == 0);
`endif
         exp_q.push_back(e);
      end
`ifdef PISO_PARITY_EN
      e.b = ^w;
      e.l = 1'b1;
      exp_q.push_back(e);
`endif
   endtask

   // Waits (bounded) for load_ready, then performs one handshake.
   task automatic send(input logic [WIDTH-1:0] w);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!load_ready && t < 50);
      if (!load_ready) begin
         check("ready_timeout", 32'(load_ready), 32'd1);
      end else begin
         load_valid = 1'b1;
         PI         = w;
         push_word(w);
         @(posedge clk);
         #1;
         load_valid = 1'b0;
         PI         = WIDTH'($urandom);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2;
      check("idle_valid", 32'(so_valid), 32'd0);
      check("idle_so", 32'(SO), 32'd0);
      check("idle_ready", 32'(load_ready), 32'd1);
   endtask

   initial begin
      int last0;
      rst        = 1'b1;
      load_valid = 1'b0;
      PI         = '0;

      // Reset held with random inputs
      @(negedge clk);
      load_valid = 1'b1;
      PI         = WIDTH'($urandom);
      @(posedge clk);
      #2;
      check("rst_so", 32'(SO), 32'd0);
      check("rst_valid", 32'(so_valid), 32'd0);
      check("rst_last", 32'(so_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      load_valid = 1'b0;
      rst        = 1'b0;

      // Single frame plus downstream SIPO view
      send(4'b1011);
      begin
         int t;
         t = 0;
         while (!so_last && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
`ifndef PISO_PARITY_EN
      @(negedge clk);
      check("sipo_q", 32'(sipo_q), 32'hB);
`endif
      drain();

      // Back-to-back frames, second loaded on the so_last cycle
      last0 = n_last;
      send(4'hA);
      send(4'h5);
      #1;
      check("b2b_nogap", 32'(so_valid), 32'd1);
      drain();
      check("b2b_last_cnt", 32'(n_last - last0), 32'd2);

      // Load attempt while busy is refused
      send(4'h0);
      @(negedge clk);
      #2;
      check("busy_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b1;
      PI         = 4'hF;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      drain();

      // Reset mid-frame drops the rest of the frame
      send(4'b1100);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("mrst_valid", 32'(so_valid), 32'd0);
      check("mrst_so", 32'(SO), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mrst_quiet", 32'(so_valid), 32'd0);
      send(4'b0110);
      drain();

`ifdef PISO_PARITY_EN
      send(4'b1001);
      drain();
`endif

      // A few random frames, some streamed back to back
      for (int k = 0; k < 6; k++) send(WIDTH'($urandom));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
